// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the restoring sequential divider: state encoding,
// default operand width and the iteration counter width.
package sequential_divider_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/sequential_divider_subtract_step.sv
// Combinational (WIDTH+1)-bit trial subtractor A - B built as A + ~B + 1
// from a chain of 2-bit carry-lookahead adder cells.
import sequential_divider_pkg::*;

module CarryLookaheadAdder_2bit (
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       Cin,
    output logic [1:0] Sum,
    output logic       Cout
);
    logic [1:0] g;
    logic [1:0] p;
    logic       c1;

    assign g    = A & B;
    assign p    = A ^ B;
    assign c1   = g[0] | (p[0] & Cin);
    assign Cout = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign Sum  = p ^ {c1, Cin};
endmodule

module subtract_step #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0] A,
    input  logic [WIDTH:0] B,
    output logic [WIDTH:0] Diff,
    output logic           NoBorrow
);
    localparam int CELLS = (WIDTH + 2) / 2;

    logic [2*CELLS-1:0] a_ext;
    logic [2*CELLS-1:0] b_inv;
    logic [2*CELLS-1:0] sum;
    logic [CELLS:0]     carry;
    logic               unused_pad_sum;

    // Padding bit is A=0, ~B=1, so the last cell's carry-out equals the
    // carry out of bit WIDTH, i.e. the no-borrow flag of the real subtraction.
    assign a_ext    = {1'b0, A};
    assign b_inv    = ~{1'b0, B};
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < CELLS; i++) begin : g_cla
        CarryLookaheadAdder_2bit u_cla (
            .A    (a_ext[2*i +: 2]),
            .B    (b_inv[2*i +: 2]),
            .Cin  (carry[i]),
            .Sum  (sum[2*i +: 2]),
            .Cout (carry[i+1])
        );
    end

    assign Diff           = sum[WIDTH:0];
    assign NoBorrow       = carry[CELLS];
    assign unused_pad_sum = sum[2*CELLS-1];
endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, Start/Done handshake.
// Define DIVIDER_SIGNED_EN to add the Signed input and the FIX sign-correction state.
module sequential_divider
    import sequential_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
`ifdef DIVIDER_SIGNED_EN
    input  logic             Signed,
`endif
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic             unused_diff_msb;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic             div_zero;
    logic             last_iter;

`ifdef DIVIDER_SIGNED_EN
    logic sign_a;
    logic sign_b;
    logic neg_q;
    logic neg_r;

    assign sign_a       = Signed & Dividend[WIDTH-1];
    assign sign_b       = Signed & Divisor[WIDTH-1];
    assign dividend_mag = sign_a ? -Dividend : Dividend;
    assign divisor_mag  = sign_b ? -Divisor : Divisor;
`else
    assign dividend_mag = Dividend;
    assign divisor_mag  = Divisor;
`endif

    assign div_zero  = (Divisor == '0);
    assign last_iter = (count == CW'(1));

    // Trial subtraction on the left-shifted partial remainder.
    assign shifted = {rem, quo[WIDTH-1]};

    subtract_step #(.WIDTH(WIDTH)) u_sub (
        .A        (shifted),
        .B        ({1'b0, dvs}),
        .Diff     (diff),
        .NoBorrow (no_borrow)
    );

    assign unused_diff_msb = diff[WIDTH];
    assign rem_next        = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next        = {quo[WIDTH-2:0], no_borrow};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (Start) state_next = div_zero ? ST_DONE : ST_ITER;
`ifdef DIVIDER_SIGNED_EN
            ST_ITER: if (last_iter) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
`else
            ST_ITER: if (last_iter) state_next = ST_DONE;
`endif
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == ST_ITER) || (state == ST_FIX);
        Done = (state == ST_DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count     <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (Start) begin
                    count     <= CW'(WIDTH);
                    rem       <= '0;
                    quo       <= dividend_mag;
                    dvs       <= divisor_mag;
                    DivByZero <= div_zero;
`ifdef DIVIDER_SIGNED_EN
                    neg_q     <= sign_a ^ sign_b;
                    neg_r     <= sign_a;
`endif
                    // Divide by zero finishes straight away with raw operands.
                    if (div_zero) begin
                        Quotient  <= '1;
                        Remainder <= Dividend;
                    end
                end
                ST_ITER: begin
                    count <= count - CW'(1);
                    rem   <= rem_next;
                    quo   <= quo_next;
`ifndef DIVIDER_SIGNED_EN
                    if (last_iter) begin
                        Quotient  <= quo_next;
                        Remainder <= rem_next;
                    end
`endif
                end
`ifdef DIVIDER_SIGNED_EN
                ST_FIX: begin
                    Quotient  <= neg_q ? -quo : quo;
                    Remainder <= neg_r ? -rem : rem;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed handshake/timing cases
// plus randomized operands checked against a plain-arithmetic model.
module tb_sequential_divider;
    localparam int W = 32;
`ifdef DIVIDER_SIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] Dividend = '0;
    logic [W-1:0] Divisor = '0;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Busy;
    logic         Done;
    logic         DivByZero;

    int n_chk = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    sequential_divider #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
`ifdef DIVIDER_SIGNED_EN
        .Signed    (sgn),
`endif
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: quotient/remainder from plain arithmetic.
    function automatic void model(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit sg,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint a;
        longint b;
        if (dv == '0) begin
            q = '1; r = dd; z = 1'b1;
        end else if (sg) begin
            a = longint'($signed(dd));
            b = longint'($signed(dv));
            q = W'(a / b);
            r = W'(a % b);
            z = 1'b0;
        end else begin
            q = dd / dv; r = dd % dv; z = 1'b0;
        end
    endfunction

    // Issue one division and observe it; returns one cycle after Done.
    task automatic do_div(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit sg,
                          output int done_cyc, output int busy_n, output int busy_first,
                          output int busy_last, output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z);
        Dividend = dd; Divisor = dv; sgn = sg; Start = 1'b1;
        tick();
        Start = 1'b0;
        done_cyc = -1; busy_n = 0; busy_first = -1; busy_last = -1;
        q = 'x; r = 'x; z = 1'bx;
        for (int c = 1; c <= LAT + 8; c++) begin
            if (Busy) begin
                busy_n++;
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (Done) begin
                done_cyc = c; q = Quotient; r = Remainder; z = DivByZero;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        n_chk++; if (Quotient !== '0)   $display("FAIL reset_q got %0h want 0", Quotient);   else n_pass++;
        n_chk++; if (Remainder !== '0)  $display("FAIL reset_r got %0h want 0", Remainder);  else n_pass++;
        n_chk++; if (Busy !== 1'b0)     $display("FAIL reset_busy got %b want 0", Busy);     else n_pass++;
        n_chk++; if (Done !== 1'b0)     $display("FAIL reset_done got %b want 0", Done);     else n_pass++;
        n_chk++; if (DivByZero !== 1'b0) $display("FAIL reset_dbz got %b want 0", DivByZero); else n_pass++;
        Reset = 1'b0;
        tick();
        n_chk++; if (Busy !== 1'b0 || Done !== 1'b0) $display("FAIL post_reset_idle got busy=%b done=%b want 0/0", Busy, Done); else n_pass++;
    endtask

    task automatic test_basic();
        int dc, bn, bf, bl;
        logic [W-1:0] q, r;
        logic z;
        do_div(32'd100, 32'd7, 1'b0, dc, bn, bf, bl, q, r, z);
        n_chk++; if (dc !== LAT)      $display("FAIL basic_done_cycle got %0d want %0d", dc, LAT); else n_pass++;
        n_chk++; if (q !== 32'd14)    $display("FAIL basic_q got %0d want 14", q); else n_pass++;
        n_chk++; if (r !== 32'd2)     $display("FAIL basic_r got %0d want 2", r); else n_pass++;
        n_chk++; if (z !== 1'b0)      $display("FAIL basic_dbz got %b want 0", z); else n_pass++;
        n_chk++; if (bf !== 1 || bl !== LAT - 1 || bn !== LAT - 1)
            $display("FAIL basic_busy got first=%0d last=%0d n=%0d want 1/%0d/%0d", bf, bl, bn, LAT - 1, LAT - 1);
        else n_pass++;
        tick();
        n_chk++; if (Quotient !== 32'd14 || Remainder !== 32'd2 || Done !== 1'b0)
            $display("FAIL basic_hold got q=%0d r=%0d done=%b want 14/2/0", Quotient, Remainder, Done);
        else n_pass++;
    endtask

    task automatic test_div_zero();
        int dc, bn, bf, bl;
        logic [W-1:0] q, r;
        logic z;
        do_div(32'd5, 32'd0, 1'b0, dc, bn, bf, bl, q, r, z);
        n_chk++; if (dc !== 1)           $display("FAIL dz_done_cycle got %0d want 1", dc); else n_pass++;
        n_chk++; if (q !== 32'hFFFFFFFF) $display("FAIL dz_q got %0h want ffffffff", q); else n_pass++;
        n_chk++; if (r !== 32'd5)        $display("FAIL dz_r got %0h want 5", r); else n_pass++;
        n_chk++; if (z !== 1'b1)         $display("FAIL dz_flag got %b want 1", z); else n_pass++;
        n_chk++; if (bn !== 0)           $display("FAIL dz_busy got %0d busy cycles want 0", bn); else n_pass++;
        n_chk++; if (DivByZero !== 1'b1) $display("FAIL dz_hold got %b want 1", DivByZero); else n_pass++;
    endtask

    task automatic test_boundary();
        logic [W-1:0] dds [6] = '{32'hFFFFFFFF, 32'd3, 32'd0, 32'd77, 32'hFFFFFFFF, 32'h80000000};
        logic [W-1:0] dvs [6] = '{32'd1, 32'hFFFFFFFF, 32'd9, 32'd77, 32'hFFFFFFFF, 32'd3};
        int dc, bn, bf, bl;
        logic [W-1:0] q, r, eq, er;
        logic z, ez;
        for (int i = 0; i < 6; i++) begin
            do_div(dds[i], dvs[i], 1'b0, dc, bn, bf, bl, q, r, z);
            model(dds[i], dvs[i], 1'b0, eq, er, ez);
            n_chk++; if (q !== eq || r !== er || z !== ez)
                $display("FAIL boundary_%0d %0h/%0h got q=%0h r=%0h z=%b want q=%0h r=%0h z=%b",
                         i, dds[i], dvs[i], q, r, z, eq, er, ez);
            else n_pass++;
        end
    endtask

    task automatic test_ignore_start();
        int dc;
        Dividend = 32'd100; Divisor = 32'd7; sgn = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        dc = -1;
        for (int c = 1; c <= LAT + 8; c++) begin
            if (c == 10) begin Start = 1'b1; Dividend = 32'd55; Divisor = 32'd3; end
            if (c == 11) Start = 1'b0;
            if (Done) begin dc = c; break; end
            tick();
        end
        n_chk++; if (dc !== LAT) $display("FAIL ignore_done_cycle got %0d want %0d", dc, LAT); else n_pass++;
        n_chk++; if (Quotient !== 32'd14 || Remainder !== 32'd2)
            $display("FAIL ignore_result got q=%0d r=%0d want 14/2", Quotient, Remainder);
        else n_pass++;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        n_chk++; if (Busy !== 1'b0 || Done !== 1'b0)
            $display("FAIL ignore_in_done got busy=%b done=%b want 0/0", Busy, Done);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        int seen_done;
        int dc, bn, bf, bl;
        logic [W-1:0] q, r;
        logic z;
        Dividend = 32'd100; Divisor = 32'd7; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c < 15; c++) tick();
        Reset = 1'b1;
        #1;
        n_chk++; if (Busy !== 1'b0 || Quotient !== '0 || Remainder !== '0)
            $display("FAIL midreset_clear got busy=%b q=%0h r=%0h want 0/0/0", Busy, Quotient, Remainder);
        else n_pass++;
        tick();
        Reset = 1'b0;
        seen_done = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            if (Done || Busy) seen_done++;
            tick();
        end
        n_chk++; if (seen_done !== 0) $display("FAIL midreset_no_done got %0d active cycles want 0", seen_done); else n_pass++;
        do_div(32'd9, 32'd3, 1'b0, dc, bn, bf, bl, q, r, z);
        n_chk++; if (q !== 32'd3 || r !== 32'd0 || dc !== LAT)
            $display("FAIL midreset_9_3 got q=%0d r=%0d done=%0d want 3/0/%0d", q, r, dc, LAT);
        else n_pass++;
    endtask

    task automatic test_random();
        int dc, bn, bf, bl;
        logic [W-1:0] dd, dv, q, r, eq, er;
        logic z, ez;
        bit sg;
        for (int i = 0; i < 40; i++) begin
            dd = $urandom;
            dv = $urandom >> $urandom_range(0, 31);
            if (i % 13 == 5) dv = '0;
`ifdef DIVIDER_SIGNED_EN
            sg = bit'($urandom_range(0, 1));
`else
            sg = 1'b0;
`endif
            do_div(dd, dv, sg, dc, bn, bf, bl, q, r, z);
            model(dd, dv, sg, eq, er, ez);
            n_chk++; if (q !== eq || r !== er || z !== ez || dc !== ((dv == '0) ? 1 : LAT))
                $display("FAIL random_%0d %0h/%0h s=%b got q=%0h r=%0h z=%b t=%0d want q=%0h r=%0h z=%b",
                         i, dd, dv, sg, q, r, z, dc, eq, er, ez);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int dc, bn, bf, bl;
        logic [W-1:0] q, r;
        logic z;
        do_div(32'd1000, 32'd33, 1'b0, dc, bn, bf, bl, q, r, z);
        // do_div returns one cycle after Done: the earliest legal next Start.
        do_div(32'd50, 32'd6, 1'b0, dc, bn, bf, bl, q, r, z);
        n_chk++; if (dc !== LAT || q !== 32'd8 || r !== 32'd2)
            $display("FAIL b2b got done=%0d q=%0d r=%0d want %0d/8/2", dc, q, r, LAT);
        else n_pass++;
    endtask

`ifdef DIVIDER_SIGNED_EN
    task automatic test_signed();
        int dc, bn, bf, bl;
        logic [W-1:0] q, r, eq, er;
        logic z, ez;
        do_div(-32'sd7, 32'd2, 1'b1, dc, bn, bf, bl, q, r, z);
        n_chk++; if (q !== 32'hFFFFFFFD || r !== 32'hFFFFFFFF || dc !== W + 2)
            $display("FAIL signed_m7_2 got q=%0h r=%0h done=%0d want fffffffd/ffffffff/%0d", q, r, dc, W + 2);
        else n_pass++;
        n_chk++; if (bf !== 1 || bl !== W + 1) $display("FAIL signed_busy got %0d..%0d want 1..%0d", bf, bl, W + 1); else n_pass++;
        do_div(-32'sd7, 32'd2, 1'b0, dc, bn, bf, bl, q, r, z);
        model(-32'sd7, 32'd2, 1'b0, eq, er, ez);
        n_chk++; if (q !== eq || r !== er) $display("FAIL unsigned_m7_2 got q=%0h r=%0h want %0h/%0h", q, r, eq, er); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundary();
        test_ignore_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
